seq_mult_unit: RTL

Multi-cycle unsigned shift-add multiplier for the 16-bit ALU datapath. It sits directly upstream of the 3-to-1 result-select mux. result_lo drives the multiply input of the mux (sel = 2'b10), and result_hi plus ovf feed the ALU flag logic. The operation controller starts it with a one-cycle start strobe and waits for done before selecting its result.

---
 rtl/seq_mult_unit.sv | 129 ++++++++++++
 1 files changed

// File: rtl/seq_mult_unit.sv
// Multi-cycle unsigned shift-add multiplier: one partial-product step per clock.
// Optional early termination with a final barrel shift: define MULT_EARLY_EXIT_EN.
module seq_mult_unit #(
  parameter int w = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [w-1:0] a,
  input  logic [w-1:0] b,
  output logic         ready,
  output logic         busy,
  output logic         done,
  output logic [w-1:0] result_lo,
  output logic [w-1:0] result_hi,
  output logic         ovf
);

  localparam int CW = $clog2(w + 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t          r_state;
  logic            r_ready;
  logic            r_busy;
  logic            r_done;
  logic [w-1:0]    r_result_lo;
  logic [w-1:0]    r_result_hi;
  logic            r_ovf;
  logic [w-1:0]    r_mcand;
  logic [w-1:0]    r_acc_hi;
  logic [w-1:0]    r_mplier;
  logic [CW-1:0]   r_count;
`ifdef MULT_EARLY_EXIT_EN
  logic [w-1:0]    r_mrem;
`endif

  logic [w:0]      w_sum;
  logic [w-1:0]    w_acc_hi_next;
  logic [w-1:0]    w_mplier_next;
  logic [CW-1:0]   w_count_next;
  logic [2*w-1:0]  w_final;
  logic            w_last;

  // {carry, acc_hi, mplier} >> 1 after the conditional add; product bits fill mplier from the top
  always_comb begin
    w_sum         = {1'b0, r_acc_hi} + (r_mplier[0] ? {1'b0, r_mcand} : {(w+1){1'b0}});
    w_acc_hi_next = w_sum[w:1];
    w_mplier_next = {w_sum[0], r_mplier[w-1:1]};
    w_count_next  = r_count - CW'(1);
`ifdef MULT_EARLY_EXIT_EN
    // Remaining steps would add nothing, so align the product by the steps skipped
    w_last  = (w_count_next == '0) || (r_mrem[w-1:1] == '0);
    w_final = {w_acc_hi_next, w_mplier_next} >> w_count_next;
`else
    w_last  = (w_count_next == '0);
    w_final = {w_acc_hi_next, w_mplier_next};
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_ready     <= 1'b1;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_result_lo <= '0;
      r_result_hi <= '0;
      r_ovf       <= 1'b0;
      r_mcand     <= '0;
      r_acc_hi    <= '0;
      r_mplier    <= '0;
      r_count     <= '0;
`ifdef MULT_EARLY_EXIT_EN
      r_mrem      <= '0;
`endif
    end else begin
      case (r_state)
        IDLE: begin
          if (start) begin
            r_mcand  <= a;
            r_mplier <= b;
            r_acc_hi <= '0;
            r_count  <= CW'(w);
`ifdef MULT_EARLY_EXIT_EN
            r_mrem   <= b;
`endif
            r_ready  <= 1'b0;
            r_busy   <= 1'b1;
            r_state  <= RUN;
          end
        end
        RUN: begin
          r_acc_hi <= w_acc_hi_next;
          r_mplier <= w_mplier_next;
          r_count  <= w_count_next;
`ifdef MULT_EARLY_EXIT_EN
          r_mrem   <= r_mrem >> 1;
`endif
          // Results change only here so the result mux never sees partial products
          if (w_last) begin
            r_result_lo <= w_final[w-1:0];
            r_result_hi <= w_final[2*w-1:w];
            r_ovf       <= |w_final[2*w-1:w];
            r_busy      <= 1'b0;
            r_done      <= 1'b1;
            r_state     <= DONE;
          end
        end
        DONE: begin
          r_done  <= 1'b0;
          r_ready <= 1'b1;
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign ready     = r_ready;
  assign busy      = r_busy;
  assign done      = r_done;
  assign result_lo = r_result_lo;
  assign result_hi = r_result_hi;
  assign ovf       = r_ovf;

endmodule
